// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF and DM requester handshakes, the
// single-port memory port, and the busy/owner status outputs.
// slave  = arbiter side, master = requesters plus memory macro side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  // Load/store requester
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  // Memory macro port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // Status
  logic              busy;
  logic              owner;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// instruction-fetch (IF) and load/store (DM) requesters. Each access runs
// IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> RESP, and the winner gets a
// one-cycle ack in RESP.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on ties;
// otherwise DM always wins over IF.
// RD_LAT must lie in 1..7 (the wait counter is 3 bits wide).
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_reg,    state_next;
  logic              owner_reg,    owner_next;
  logic              we_reg,       we_next;
  logic [ADDR_W-1:0] addr_reg,     addr_next;
  logic [DATA_W-1:0] wdata_reg,    wdata_next;
  logic [2:0]        cnt_reg,      cnt_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] dm_rdata_reg, dm_rdata_next;
  logic              grant_dm;

`ifdef MEM_ARB_RR_EN
  logic last_owner_reg, last_owner_next;

  // Round-robin: on a tie the requester that was not served last wins
  assign grant_dm = bus.dm_req && (!bus.if_req || !last_owner_reg);
`else
  // Fixed priority: a pending load/store always beats a fetch
  assign grant_dm = bus.dm_req;
`endif

  // Access sequencer: next state, request latching and read-data capture
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    cnt_next      = cnt_reg;
    if_rdata_next = if_rdata_reg;
    dm_rdata_next = dm_rdata_reg;
`ifdef MEM_ARB_RR_EN
    last_owner_next = last_owner_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (bus.dm_req || bus.if_req) begin
          owner_next = grant_dm;
          if (grant_dm) begin
            addr_next  = bus.dm_addr;
            wdata_next = bus.dm_wdata;
            we_next    = bus.dm_we;
          end else begin
            // Fetches are always reads; wdata keeps its old value
            addr_next = bus.if_addr;
            we_next   = 1'b0;
          end
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_reg) begin
          state_next = S_RESP;
        end else begin
          cnt_next   = RD_LAT_C;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg == 3'd1) begin
          // Memory data is valid in this last wait cycle
          if (owner_reg) dm_rdata_next = bus.mem_rdata;
          else           if_rdata_next = bus.mem_rdata;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
`ifdef MEM_ARB_RR_EN
        last_owner_next = owner_reg;
`endif
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and latch registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      owner_reg    <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      cnt_reg      <= '0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      cnt_reg      <= cnt_next;
      if_rdata_reg <= if_rdata_next;
      dm_rdata_reg <= dm_rdata_next;
`ifdef MEM_ARB_RR_EN
      last_owner_reg <= last_owner_next;
`endif
    end
  end

  // Outputs decode straight from registered state so reset clears them at once
  assign bus.mem_en    = (state_reg == S_ISSUE);
  assign bus.mem_we    = (state_reg == S_ISSUE) && we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.if_ack    = (state_reg == S_RESP) && !owner_reg;
  assign bus.dm_ack    = (state_reg == S_RESP) && owner_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.dm_rdata  = dm_rdata_reg;
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.owner     = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: one instance with RD_LAT=1 (scoreboarded
// by an ack monitor) and one with RD_LAT=3 for the long-latency read.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Cycle counter: value seen at a negedge names the current cycle
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3));

  // Power-on memory contents
  function automatic logic [31:0] init_pat(input logic [9:0] a);
    if (a == 10'h004) return 32'h1234ABCD;
    if (a == 10'h3FF) return 32'hA5A50FF0;
    return {16'hC0DE, 6'b0, a};
  endfunction

  // Memory model, latency 1; junk on the read bus when no read was issued
  logic [31:0] mem1 [0:1023];
  logic        wr1  [0:1023];
  logic [31:0] pipe1;
  always @(posedge clk) begin
    if (bus1.mem_en && bus1.mem_we) begin
      mem1[bus1.mem_addr] <= bus1.mem_wdata;
      wr1[bus1.mem_addr]  <= 1'b1;
    end
    if (bus1.mem_en && !bus1.mem_we)
      pipe1 <= (wr1[bus1.mem_addr] === 1'b1) ? mem1[bus1.mem_addr] : init_pat(bus1.mem_addr);
    else
      pipe1 <= {16'hBAD1, cyc[15:0]};
  end
  assign bus1.mem_rdata = pipe1;

  // Memory model, latency 3 (read only)
  logic [31:0] pipe3a, pipe3b, pipe3c;
  always @(posedge clk) begin
    pipe3a <= (bus3.mem_en && !bus3.mem_we) ? init_pat(bus3.mem_addr) : {16'hBAD3, cyc[15:0]};
    pipe3b <= pipe3a;
    pipe3c <= pipe3b;
  end
  assign bus3.mem_rdata = pipe3c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected acks on instance 1
  typedef struct {
    bit          is_dm;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sb[$];
  bit   last_model;

  task automatic push(input bit dm, input logic [31:0] data, input int at);
    exp_t e;
    e.is_dm = dm;
    e.data  = data;
    e.at    = at;
    sb.push_back(e);
  endtask

  // Ack monitor: every ack must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      last_model <= 1'b0;
    end else if (bus1.if_ack || bus1.dm_ack) begin
      check("ack_expected", 32'(sb.size() != 0), 32'd1);
      check("ack_one_hot", 32'(bus1.if_ack && bus1.dm_ack), 32'd0);
      if (sb.size() != 0) begin
        check("ack_owner", 32'(bus1.dm_ack), 32'(sb[0].is_dm));
        check("ack_cycle", cyc, sb[0].at);
        check("ack_rdata", sb[0].is_dm ? bus1.dm_rdata : bus1.if_rdata, sb[0].data);
        $display("txn %s ack cycle=%0d rdata=0x%08h expected=0x%08h",
                 sb[0].is_dm ? "DM" : "IF", cyc,
                 sb[0].is_dm ? bus1.dm_rdata : bus1.if_rdata, sb[0].data);
        last_model <= sb[0].is_dm;
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Wait for an ack on instance 1 within a cycle budget, then drop the request
  task automatic wait_ack1(input bit dm, input int budget);
    int n;
    n = 0;
    while (!(dm ? bus1.dm_ack : bus1.if_ack) && n < budget) begin
      tick();
      n++;
    end
    check(dm ? "dm_ack_timeout" : "if_ack_timeout", 32'(n < budget), 32'd1);
    if (dm) bus1.dm_req = 1'b0;
    else    bus1.if_req = 1'b0;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  int          c0;
  int          n;
  bit          tie_w;
  logic [31:0] exp_dm;
  logic [9:0]  ia, da;

  initial begin
    rst_n = 1'b0;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.dm_req = 1'b0; bus1.dm_we = 1'b0;
    bus1.dm_addr = '0; bus1.dm_wdata = '0;
    bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.dm_req = 1'b0; bus3.dm_we = 1'b0;
    bus3.dm_addr = '0; bus3.dm_wdata = '0;
    exp_dm = '0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", 32'(bus1.busy), 32'd0);
    check("rst_mem_en", 32'(bus1.mem_en), 32'd0);
    check("rst_owner", 32'(bus1.owner), 32'd0);
    check("rst_acks", 32'({bus1.if_ack, bus1.dm_ack}), 32'd0);
    check("rst_if_rdata", bus1.if_rdata, 32'd0);
    check("rst_dm_rdata", bus1.dm_rdata, 32'd0);
    check("rst_mem_addr", 32'(bus1.mem_addr), 32'd0);
    check("rst3_busy", 32'(bus3.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // IF read of 0x004, latency 1
    c0 = cyc;
    bus1.if_addr = 10'h004;
    bus1.if_req  = 1'b1;
    push(1'b0, 32'h1234ABCD, c0 + 3);
    tick();
    check("if_issue_en", 32'(bus1.mem_en), 32'd1);
    check("if_issue_addr", 32'(bus1.mem_addr), 32'h004);
    check("if_issue_we", 32'(bus1.mem_we), 32'd0);
    check("if_issue_busy", 32'(bus1.busy), 32'd1);
    tick();
    check("if_wait_en", 32'(bus1.mem_en), 32'd0);
    check("if_wait_ack", 32'(bus1.if_ack), 32'd0);
    wait_ack1(1'b0, 5);
    tick();
    check("if_done_busy", 32'(bus1.busy), 32'd0);

    // DM store to 0x010: dm_rdata must stay as it was
    c0 = cyc;
    bus1.dm_we = 1'b1; bus1.dm_addr = 10'h010; bus1.dm_wdata = 32'hDEADBEEF;
    bus1.dm_req = 1'b1;
    push(1'b1, exp_dm, c0 + 2);
    tick();
    check("st_issue_en", 32'(bus1.mem_en), 32'd1);
    check("st_issue_we", 32'(bus1.mem_we), 32'd1);
    check("st_issue_addr", 32'(bus1.mem_addr), 32'h010);
    check("st_issue_wdata", bus1.mem_wdata, 32'hDEADBEEF);
    check("st_issue_owner", 32'(bus1.owner), 32'd1);
    wait_ack1(1'b1, 5);
    tick();
    check("st_after_we", 32'(bus1.mem_we), 32'd0);

    // DM load back from 0x010
    c0 = cyc;
    bus1.dm_we = 1'b0;
    bus1.dm_req = 1'b1;
    push(1'b1, 32'hDEADBEEF, c0 + 3);
    exp_dm = 32'hDEADBEEF;
    wait_ack1(1'b1, 8);
    tick();

    // Reset during WAIT of a DM load: no ack, outputs clear at once
    bus1.dm_addr = 10'h030;
    bus1.dm_req  = 1'b1;
    tick();
    check("rw_issue_owner", 32'(bus1.owner), 32'd1);
    tick();
    check("rw_wait_busy", 32'(bus1.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rw_mem_en", 32'(bus1.mem_en), 32'd0);
    check("rw_busy", 32'(bus1.busy), 32'd0);
    check("rw_owner", 32'(bus1.owner), 32'd0);
    check("rw_acks", 32'({bus1.if_ack, bus1.dm_ack}), 32'd0);
    check("rw_dm_rdata", bus1.dm_rdata, 32'd0);
    bus1.dm_req = 1'b0;
    exp_dm = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rw_idle_busy", 32'(bus1.busy), 32'd0);

    // Fresh IF read after reset release
    c0 = cyc;
    bus1.if_addr = 10'h03C;
    bus1.if_req  = 1'b1;
    push(1'b0, init_pat(10'h03C), c0 + 3);
    wait_ack1(1'b0, 8);
    tick();

    // Two rounds of simultaneous requests
    for (int p = 0; p < 2; p++) begin
`ifdef MEM_ARB_RR_EN
      tie_w = !last_model;
`else
      tie_w = 1'b1;
`endif
      c0 = cyc;
      da = 10'h020 + 10'(4 * p);
      ia = 10'h008 + 10'(4 * p);
      bus1.dm_we = 1'b0; bus1.dm_addr = da; bus1.if_addr = ia;
      bus1.dm_req = 1'b1; bus1.if_req = 1'b1;
      push(tie_w,  tie_w ? init_pat(da) : init_pat(ia), c0 + 3);
      push(!tie_w, tie_w ? init_pat(ia) : init_pat(da), c0 + 7);
      if (tie_w) exp_dm = init_pat(da);
      else       exp_dm = init_pat(da);
      tick();
      check("tie_first_owner", 32'(bus1.owner), 32'(tie_w));
      n = 0;
      while ((bus1.if_req || bus1.dm_req) && n < 12) begin
        if (bus1.dm_ack) bus1.dm_req = 1'b0;
        if (bus1.if_ack) bus1.if_req = 1'b0;
        if (bus1.if_req || bus1.dm_req) begin
          tick();
          n++;
        end
      end
      check("tie_both_served", 32'(bus1.if_req || bus1.dm_req), 32'd0);
      tick();
    end

    // DM load with dm_req dropped in WAIT: exactly one ack, no new access
    c0 = cyc;
    bus1.dm_addr = 10'h044;
    bus1.dm_req  = 1'b1;
    push(1'b1, init_pat(10'h044), c0 + 3);
    tick();
    tick();
    bus1.dm_req = 1'b0;
    tick();
    check("drop_ack", 32'(bus1.dm_ack), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("drop_idle_busy", 32'(bus1.busy), 32'd0);
      check("drop_idle_en", 32'(bus1.mem_en), 32'd0);
    end

    // RD_LAT=3 fetch from the top address
    c0 = cyc;
    bus3.if_addr = 10'h3FF;
    bus3.if_req  = 1'b1;
    tick();
    check("l3_issue_en", 32'(bus3.mem_en), 32'd1);
    check("l3_issue_addr", 32'(bus3.mem_addr), 32'h3FF);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("l3_wait_en", 32'(bus3.mem_en), 32'd0);
      check("l3_wait_ack", 32'(bus3.if_ack), 32'd0);
      check("l3_wait_busy", 32'(bus3.busy), 32'd1);
    end
    check("l3_mem_rdata_c4", bus3.mem_rdata, 32'hA5A50FF0);
    tick();
    check("l3_ack", 32'(bus3.if_ack), 32'd1);
    check("l3_ack_cycle", cyc, c0 + 5);
    check("l3_rdata", bus3.if_rdata, 32'hA5A50FF0);
    $display("txn IF(lat3) ack cycle=%0d rdata=0x%08h expected=0x%08h",
             cyc, bus3.if_rdata, 32'hA5A50FF0);
    bus3.if_req = 1'b0;
    tick();
    check("l3_after_ack", 32'(bus3.if_ack), 32'd0);
    check("l3_after_busy", 32'(bus3.busy), 32'd0);
    check("l3_rdata_hold", bus3.if_rdata, 32'hA5A50FF0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("dm_rdata_final", bus1.dm_rdata, init_pat(10'h044));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data/instruction memory between the instruction-fetch requester (IF) and the load/store requester (DM) of the multicycle processor.
- Sequences every access as IDLE -> ISSUE -> (WAIT) -> RESP, inserting the memory's read latency.
- Returns a one-cycle ack to the winning requester. Sits between the control-unit-driven datapath and the memory macro.

Parameters:
- ADDR_W, 10, word-address width of both requesters and the memory port.
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles: mem_rdata is valid RD_LAT cycles after the ISSUE cycle. Legal range 1..7; 0 is illegal.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high with stable if_addr until if_ack.
- if_addr  in  ADDR_W  fetch word address.
- if_ack  out  1  one-cycle completion pulse to IF.
- if_rdata  out  DATA_W  fetched word; valid from the if_ack cycle until the next IF read completes.
- dm_req  in  1  load/store request; dm_we/dm_addr/dm_wdata stable until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  DATA_W  store data.
- dm_ack  out  1  one-cycle completion pulse to DM.
- dm_rdata  out  DATA_W  load data; valid from the dm_ack cycle until the next DM load completes.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in every state except IDLE.
- owner  out  1  latched grant: 0 = IF, 1 = DM.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; internal latches and wait counter 0. In RR mode, last_owner=0.
- Reset mid-transaction: the access is abandoned, no ack is issued, and mem_en drops immediately.
- IDLE:
  - Sample requests. If none is pending, stay in IDLE.
  - Otherwise choose a winner, latch its addr/wdata/we into internal registers, set owner, and go to ISSUE.
  - An IF access always latches we=0.
- ISSUE (1 cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latches.
  - Write: go to RESP.
  - Read: load the wait counter with RD_LAT and go to WAIT.
- WAIT:
  - mem_en=0 and mem_we=0; decrement the counter each cycle.
  - In the cycle where counter==1, capture mem_rdata into if_rdata or dm_rdata (per owner) at the edge and go to RESP.
- RESP (1 cycle):
  - Assert if_ack or dm_ack per owner, then go to IDLE.
  - A store never changes dm_rdata.
- mem_addr and mem_wdata hold their latched values outside ISSUE. mem_en and mem_we are 1 only in ISSUE.
- Latency, counting from the req-sampled IDLE cycle as cycle 0:
  - Write: ack in cycle 2.
  - Read: ack in cycle 2+RD_LAT.
  - RESP->IDLE costs 1 cycle, so back-to-back accesses start every 3 (write) or 3+RD_LAT (read) cycles.
- Requesters must drop req in the cycle after ack. A req still high in IDLE is treated as a new access.
- If req deasserts mid-transaction, the access still completes and the ack still pulses.
- Requests arriving outside IDLE are not sampled until the next IDLE.
- Arbitration (default): fixed priority, DM over IF. This guarantees an in-flight instruction's load/store completes before the next fetch.
- Simultaneous if_req and dm_req in IDLE: DM wins; IF stays pending and is served in the next IDLE.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last_owner register updates at each RESP.
  - On a tie, the requester that is not last_owner wins.
  - With a single requester, that requester wins.
  - The reset value last_owner=0 makes DM win the first tie.
- Undefined: fixed DM-over-IF priority; no last_owner register is built.

Test Plan:
- Reset, then IF read: if_req=1, if_addr=0x004, mem[4]=0x1234ABCD, RD_LAT=1 -> mem_en=1 with mem_addr=0x004 in cycle 1; if_ack=1 and if_rdata=0x1234ABCD in cycle 3; busy=0 in cycle 4.
- DM store then load: dm_we=1, addr=0x010, wdata=0xDEADBEEF -> mem_we=1 in cycle 1, dm_ack in cycle 2, dm_rdata unchanged. A following load from 0x010 returns 0xDEADBEEF with its dm_ack 3 cycles after its IDLE.
- Simultaneous if_req and dm_req (load, addr 0x020), fixed mode -> DM served first (owner=1), IF served second; with MEM_ARB_RR_EN repeated ties alternate DM, IF, DM, IF.
- RD_LAT=3 read of 0x3FF (address wrap edge) -> exactly 3 WAIT cycles; ack in cycle 5; the data captured equals mem_rdata of cycle 4.
- rst_n pulled low in a WAIT cycle -> mem_en, busy, owner and acks go 0 immediately with no ack. After release, a fresh IF request completes normally.
- dm_req dropped during WAIT -> dm_ack still pulses once; no second access is started.
